// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: byte FIFO, overrun, idle timeout, interrupt
//
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (idle-timeout FSM and counter).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   baud_x16_tick     1-cycle pulse at 16x baud (timeout time base)
//   rx_busy_in        receive engine is mid-frame
//   rx_in_valid/ready/data  byte stream from the receive engine (ready is always 1)
//   ctrl_en           receive enable; bytes are discarded while low
//   ctrl_flush        1-cycle FIFO flush
//   thresh            level interrupt threshold (0 disables)
//   rd_pop/rd_data/rd_valid  first-word fall-through read side
//   level             FIFO occupancy
//   overrun/overrun_clr  sticky drop flag and its clear
//   timeout_flag      idle timeout fired with data pending
//   irq               registered combined interrupt
module uart_rx_ctrl #(
    parameter int DEPTH    = 8,
    parameter int TO_TICKS = 640,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          baud_x16_tick,
    input  logic          rx_busy_in,
    input  logic          rx_in_valid,
    output logic          rx_in_ready,
    input  logic [7:0]    rx_in_data,
    input  logic          ctrl_en,
    input  logic          ctrl_flush,
    input  logic [LW-1:0] thresh,
    input  logic          rd_pop,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [LW-1:0] level,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic          timeout_flag,
    output logic          irq
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          pop_acc;
    logic          push_acc;
    logic          drop;
    logic          lvl_irq;

    assign rx_in_ready = 1'b1;
    assign full        = (level == FULL_LVL);
    assign rd_valid    = (level != '0);
    assign rd_data     = mem[rptr];

    // A flush swallows both sides of the FIFO in its cycle. A pop frees
    // a slot in the same cycle, so a push on a full FIFO is kept then.
    assign pop_acc  = rd_pop && (level != '0) && !ctrl_flush;
    assign push_acc = rx_in_valid && ctrl_en && !ctrl_flush && (!full || pop_acc);
    assign drop     = rx_in_valid && ctrl_en && !ctrl_flush && full && !pop_acc;

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wptr] <= rx_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (ctrl_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Set wins over clear when a drop coincides with overrun_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TO_TICKS + 1);

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_FIRED = 2'd2
    } t_state_e;

    t_state_e      t_state;
    t_state_e      t_state_nxt;
    logic [CW-1:0] t_cnt;
    logic [CW-1:0] t_cnt_nxt;
    logic          activity;

    // Any engine byte (accepted or not), accepted pop, or a frame in
    // progress means the line is not idle.
    assign activity = rx_in_valid || pop_acc || rx_busy_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state <= T_IDLE;
            t_cnt   <= '0;
        end else begin
            t_state <= t_state_nxt;
            t_cnt   <= t_cnt_nxt;
        end
    end

    always_comb begin
        t_state_nxt = t_state;
        t_cnt_nxt   = t_cnt;
        case (t_state)
            T_IDLE: begin
                t_cnt_nxt = '0;
                if (!ctrl_flush && (level != '0) && !activity) begin
                    t_state_nxt = T_COUNT;
                end
            end
            T_COUNT: begin
                if (ctrl_flush || activity || (level == '0)) begin
                    t_state_nxt = T_IDLE;
                    t_cnt_nxt   = '0;
                end else if (baud_x16_tick) begin
                    t_cnt_nxt = t_cnt + 1'b1;
                    if (t_cnt == CW'(TO_TICKS - 1)) begin
                        t_state_nxt = T_FIRED;
                    end
                end
            end
            T_FIRED: begin
                // A push leaves the flag up; only draining or flushing clears it.
                if (ctrl_flush || pop_acc) begin
                    t_state_nxt = T_IDLE;
                    t_cnt_nxt   = '0;
                end
            end
            default: begin
                t_state_nxt = T_IDLE;
                t_cnt_nxt   = '0;
            end
        endcase
    end

    assign timeout_flag = (t_state == T_FIRED);
`else
    localparam int UNUSED_TO_TICKS = TO_TICKS;
    logic unused_timeout_inputs;
    assign unused_timeout_inputs = baud_x16_tick ^ rx_busy_in ^ (UNUSED_TO_TICKS != 0);
    assign timeout_flag = 1'b0;
`endif

    assign lvl_irq = (thresh != '0) && (level >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= lvl_irq || timeout_flag || overrun;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          baud_x16_tick;
    logic          rx_busy_in;
    logic          rx_in_valid;
    logic          rx_in_ready;
    logic [7:0]    rx_in_data;
    logic          ctrl_en;
    logic          ctrl_flush;
    logic [LW-1:0] thresh;
    logic          rd_pop;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          overrun;
    logic          overrun_clr;
    logic          timeout_flag;
    logic          irq;

    int         checks   = 0;
    int         failures = 0;
    int         mdl_level = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TO_TICKS(640)) dut (
        .clk(clk), .rst_n(rst_n), .baud_x16_tick(baud_x16_tick), .rx_busy_in(rx_busy_in),
        .rx_in_valid(rx_in_valid), .rx_in_ready(rx_in_ready), .rx_in_data(rx_in_data),
        .ctrl_en(ctrl_en), .ctrl_flush(ctrl_flush), .thresh(thresh), .rd_pop(rd_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .overrun(overrun),
        .overrun_clr(overrun_clr), .timeout_flag(timeout_flag), .irq(irq)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_in_valid = 1'b1;
        rx_in_data  = d;
        if (ctrl_en && mdl_level < DEPTH) begin
            sb.push_back(d);
            mdl_level++;
        end
        step();
        rx_in_valid = 1'b0;
    endtask

    task automatic pop_byte;
        logic [7:0] e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL pop_sb_empty: scoreboard empty, level=%0d required nonzero", level);
        end else begin
            e = sb.pop_front();
            if (rd_data !== e) begin
                failures++;
                $display("FAIL pop_data: got %02h required %02h", rd_data, e);
            end
            mdl_level--;
        end
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
        checks++;
        if (level !== LW'(mdl_level)) begin
            failures++;
            $display("FAIL pop_level: got %0d required %0d", level, mdl_level);
        end
    endtask

    task automatic tick;
        baud_x16_tick = 1'b1;
        step();
        baud_x16_tick = 1'b0;
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (rx_in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", rx_in_ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", rd_valid); end
        checks++; if (level !== '0) begin failures++; $display("FAIL rst_level: got %0d required 0", level); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b required 0", overrun); end
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b required 0", timeout_flag); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b required 0", irq); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        checks++; if (level !== 3) begin failures++; $display("FAIL basic_level: got %0d required 3", level); end
        repeat (3) pop_byte();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid: got %b required 0", rd_valid); end
    endtask

    task automatic test_disabled;
        ctrl_en = 1'b0;
        push_byte(8'hE1);
        ctrl_en = 1'b1;
        step();
        checks++; if (level !== 0) begin failures++; $display("FAIL dis_level: got %0d required 0", level); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL dis_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 9; i++) push_byte(8'(i));
        checks++; if (level !== 8) begin failures++; $display("FAIL ovr_level: got %0d required 8", level); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b required 1", overrun); end
        repeat (8) pop_byte();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %b required 0", overrun); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] e;
        for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
        e = sb.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL fpp_head: got %02h required %02h", rd_data, e); end
        sb.push_back(8'hAA);
        rx_in_valid = 1'b1;
        rx_in_data  = 8'hAA;
        rd_pop      = 1'b1;
        step();
        rx_in_valid = 1'b0;
        rd_pop      = 1'b0;
        checks++; if (level !== 8) begin failures++; $display("FAIL fpp_level: got %0d required 8", level); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL fpp_overrun: got %b required 0", overrun); end
        repeat (8) pop_byte();
    endtask

    task automatic test_irq;
        thresh = 4'd4;
        for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b required 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b required 1", irq); end
        pop_byte();
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr: got %b required 0", irq); end
        thresh = '0;
        repeat (3) pop_byte();
    endtask

    task automatic test_flush;
        for (int i = 0; i < 9; i++) push_byte(8'h80 + 8'(i));
        ctrl_flush  = 1'b1;
        rx_in_valid = 1'b1;
        rx_in_data  = 8'h55;
        step();
        ctrl_flush  = 1'b0;
        rx_in_valid = 1'b0;
        sb.delete();
        mdl_level = 0;
        checks++; if (level !== 0) begin failures++; $display("FAIL fl_level: got %0d required 0", level); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL fl_valid: got %b required 0", rd_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL fl_overrun: got %b required 1", overrun); end
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
        checks++; if (level !== 0) begin failures++; $display("FAIL fl_pop_empty: got %0d required 0", level); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        push_byte(8'h77);
        pop_byte();
    endtask

    task automatic test_timeout;
        push_byte(8'hC1);
        step();
`ifdef UART_RX_CTRL_TIMEOUT_EN
        repeat (639) tick();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_early: got %b required 0", timeout_flag); end
        baud_x16_tick = 1'b1;
        step();
        baud_x16_tick = 1'b0;
        checks++; if (timeout_flag !== 1'b1) begin failures++; $display("FAIL to_fire: got %b required 1", timeout_flag); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL to_irq: got %b required 1", irq); end
        pop_byte();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_pop_clr: got %b required 0", timeout_flag); end
        push_byte(8'hC2);
        step();
        repeat (600) tick();
        push_byte(8'hC3);
        step();
        repeat (639) tick();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_restart: got %b required 0", timeout_flag); end
        tick();
        checks++; if (timeout_flag !== 1'b1) begin failures++; $display("FAIL to_refire: got %b required 1", timeout_flag); end
`else
        repeat (700) tick();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_disabled: got %b required 0", timeout_flag); end
`endif
        while (sb.size() != 0) pop_byte();
        step();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_drained: got %b required 0", timeout_flag); end
    endtask

    task automatic test_reset_mid;
        push_byte(8'hD0);
        push_byte(8'hD1);
        push_byte(8'hD2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (level !== 0) begin failures++; $display("FAIL mid_rst_level: got %0d required 0", level); end
        sb.delete();
        mdl_level = 0;
        step();
        rst_n = 1'b1;
        step();
        push_byte(8'h99);
        checks++; if (level !== 1) begin failures++; $display("FAIL mid_rst_push: got %0d required 1", level); end
        pop_byte();
    endtask

    initial begin
        baud_x16_tick = 1'b0;
        rx_busy_in    = 1'b0;
        rx_in_valid   = 1'b0;
        rx_in_data    = '0;
        ctrl_en       = 1'b1;
        ctrl_flush    = 1'b0;
        thresh        = '0;
        rd_pop        = 1'b0;
        overrun_clr   = 1'b0;
        test_reset();
        test_basic();
        test_disabled();
        test_overrun();
        test_full_push_pop();
        test_irq();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
